// File: rtl/bp_pkg.sv
// Shared encodings and counter constants for the BHT branch predictor.
// The optional gshare mode (BP_GSHARE_EN) lives in branch_predictor_bht.
package bp_pkg;

    typedef enum logic [1:0] {
        BS_UNCOND = 2'b00,
        BS_CONDZ  = 2'b01,
        BS_CONDC  = 2'b10,
        BS_NONE   = 2'b11
    } bs_e;

    localparam int CTR_W_DEF = 2;
    typedef logic [CTR_W_DEF-1:0] ctr_t;

    // Weakly-not-taken: one step below the taken threshold.
    localparam ctr_t CTR_RST = ctr_t'((1 << (CTR_W_DEF - 1)) - 1);

    function automatic logic is_cond(input logic [1:0] bs);
        return (bs == BS_CONDZ) || (bs == BS_CONDC);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One saturating up/down counter of the branch history table.
// Resets to weakly-not-taken; holds at 0 and all-ones.
module bp_sat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] cnt_o
);

    localparam logic [CTR_W-1:0] CNT_MAX = '1;
    localparam logic [CTR_W-1:0] CNT_RST = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (inc_i) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CTR_W'(1);
            end else begin
                if (cnt_q != '0) cnt_d = cnt_q - CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= CNT_RST;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table with registered lookup and execute-stage training.
// Define BP_GSHARE_EN to XOR a non-speculative global history into both indices.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IDX_W = 4,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lu_valid_i,
    input  logic [PC_W-1:0]  lu_pc_i,
    input  logic [1:0]       lu_bs_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [IDX_W-1:0] pred_ghr_o,
    input  logic             upd_valid_i,
    input  logic [PC_W-1:0]  upd_pc_i,
    input  logic [1:0]       upd_bs_i,
    input  logic             upd_taken_i,
    input  logic [IDX_W-1:0] upd_ghr_i,
    output logic             mispredict_o
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0][CTR_W-1:0] ctr;
    logic [IDX_W-1:0] lu_idx, upd_idx, lu_ghr;
    logic             upd_cond;

    assign upd_cond = upd_valid_i && is_cond(upd_bs_i);

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;
    logic             unused_pc;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_cond) ghr_d = (ghr_q << 1) | IDX_W'(upd_taken_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end

    assign lu_idx    = lu_pc_i[IDX_W-1:0] ^ ghr_q;
    assign upd_idx   = upd_pc_i[IDX_W-1:0] ^ upd_ghr_i;
    assign lu_ghr    = ghr_q;
    assign unused_pc = ^{lu_pc_i, upd_pc_i};
`else
    logic unused_in;

    assign lu_idx    = lu_pc_i[IDX_W-1:0];
    assign upd_idx   = upd_pc_i[IDX_W-1:0];
    assign lu_ghr    = '0;
    assign unused_in = ^{lu_pc_i, upd_pc_i, upd_ghr_i};
`endif

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (upd_cond && (upd_idx == IDX_W'(i))),
            .inc_i (upd_taken_i),
            .cnt_o (ctr[i])
        );
    end

    // Reads see the counter before this cycle's training lands (read-before-write).
    logic             lu_msb, upd_msb;
    logic             pred_valid_q, pred_taken_q, mispredict_q;
    logic             pred_taken_d, mispredict_d;
    logic [IDX_W-1:0] pred_ghr_q, pred_ghr_d;

    assign lu_msb  = ctr[lu_idx][CTR_W-1];
    assign upd_msb = ctr[upd_idx][CTR_W-1];

    always_comb begin
        pred_taken_d = 1'b0;
        if (lu_valid_i) begin
            unique case (lu_bs_i)
                BS_UNCOND: pred_taken_d = 1'b1;
                BS_NONE:   pred_taken_d = 1'b0;
                default:   pred_taken_d = lu_msb;
            endcase
        end
        pred_ghr_d   = lu_valid_i ? lu_ghr : '0;
        mispredict_d = upd_cond && (upd_msb != upd_taken_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
            mispredict_q <= 1'b0;
        end else begin
            pred_valid_q <= lu_valid_i;
            pred_taken_q <= pred_taken_d;
            pred_ghr_q   <= pred_ghr_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_ghr_o   = pred_ghr_q;
    assign mispredict_o = mispredict_q;

endmodule
